// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the per-stage
// hazard-tracking record used by the hazard controller.
package pipe_hazard_ctrl_pkg;

    // Register specifiers are stored at this fixed width; narrower REG_AW is zero-extended.
    localparam int unsigned PIPE_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_MX = 2'b01,
        FWD_WX = 2'b10
    } fwd_sel_e;

    typedef logic [PIPE_AW_MAX-1:0] reg_spec_t;

    typedef struct packed {
        logic      valid;
        reg_spec_t rs;
        reg_spec_t rt;
        reg_spec_t rd;
        logic      uses_rs;
        logic      uses_rt;
        logic      rwe;
        logic      is_load;
        logic      is_store;
    } pipe_entry_t;

    localparam pipe_entry_t ENTRY_EMPTY = '0;

    function automatic fwd_sel_e fwd_pick(input logic mx_hit, input logic wx_hit);
        if (mx_hit) return FWD_MX;
        if (wx_hit) return FWD_WX;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_entry_match.sv
// Live-producer comparator: one pipeline entry against one source specifier.
// Register 0 is hard-wired, so a producer writing it never matches.
module hazard_entry_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic      i_valid,
    input  logic      i_rwe,
    input  reg_spec_t i_rd,
    input  reg_spec_t i_src,
    input  logic      i_use,
    output logic      o_match
);

    assign o_match = i_valid & i_rwe & (i_rd != '0) & i_use & (i_rd == i_src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use / interlock stalls, MX/WX/WM
// bypass selects, branch flush, memory freeze and saturating event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rt,
    input  logic              dec_rwe,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              stall,
    output logic              bubble_dx,
    output logic              flush_fd,
    output logic              freeze,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              fwd_wm,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    if (REG_AW == 0 || REG_AW > PIPE_AW_MAX) begin : g_bad_reg_aw
        $error("pipe_hazard_ctrl: REG_AW must be 1..PIPE_AW_MAX");
    end

    pipe_entry_t      r_dx, r_xm, r_mw;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    pipe_entry_t w_dec, w_dx_next;
    pipe_entry_t w_ent [3];
    logic [2:0]  w_dec_rs_hit, w_dec_rt_hit;
    logic        w_rt_use, w_stall_raw;
    logic        w_a_mx, w_a_wx, w_b_mx, w_b_wx, w_wm_hit;
    logic        w_unused;

    // NOTE: every field gets a default before the partial writes, so no latch is inferred.
    always_comb begin
        w_dec                = ENTRY_EMPTY;
        w_dec.valid          = dec_valid;
        w_dec.uses_rs        = dec_uses_rs;
        w_dec.uses_rt        = dec_uses_rt;
        w_dec.rwe            = dec_rwe;
        w_dec.is_load        = dec_is_load;
        w_dec.is_store       = dec_is_store;
        w_dec.rs[REG_AW-1:0] = dec_rs;
        w_dec.rt[REG_AW-1:0] = dec_rt;
        w_dec.rd[REG_AW-1:0] = dec_rd;
    end

    assign w_ent[0] = r_dx;
    assign w_ent[1] = r_xm;
    assign w_ent[2] = r_mw;

    // In bypass mode store data comes through the WM path, so a store's rt never stalls.
    assign w_rt_use = dec_uses_rt & (!FWD_EN | !dec_is_store);

    for (genvar e = 0; e < 3; e++) begin : g_dec_match
        hazard_entry_match u_rs (
            .i_valid(w_ent[e].valid), .i_rwe(w_ent[e].rwe), .i_rd(w_ent[e].rd),
            .i_src(w_dec.rs), .i_use(dec_uses_rs), .o_match(w_dec_rs_hit[e])
        );
        hazard_entry_match u_rt (
            .i_valid(w_ent[e].valid), .i_rwe(w_ent[e].rwe), .i_rd(w_ent[e].rd),
            .i_src(w_dec.rt), .i_use(w_rt_use), .o_match(w_dec_rt_hit[e])
        );
    end

    if (FWD_EN) begin : g_bypass
        assign w_stall_raw = r_dx.is_load & (w_dec_rs_hit[0] | w_dec_rt_hit[0]);
    end else begin : g_interlock
        assign w_stall_raw = (|w_dec_rs_hit) | (|w_dec_rt_hit);
    end

    hazard_entry_match u_a_mx (
        .i_valid(r_xm.valid), .i_rwe(r_xm.rwe), .i_rd(r_xm.rd),
        .i_src(r_dx.rs), .i_use(r_dx.uses_rs), .o_match(w_a_mx)
    );
    hazard_entry_match u_a_wx (
        .i_valid(r_mw.valid), .i_rwe(r_mw.rwe), .i_rd(r_mw.rd),
        .i_src(r_dx.rs), .i_use(r_dx.uses_rs), .o_match(w_a_wx)
    );
    hazard_entry_match u_b_mx (
        .i_valid(r_xm.valid), .i_rwe(r_xm.rwe), .i_rd(r_xm.rd),
        .i_src(r_dx.rt), .i_use(r_dx.uses_rt), .o_match(w_b_mx)
    );
    hazard_entry_match u_b_wx (
        .i_valid(r_mw.valid), .i_rwe(r_mw.rwe), .i_rd(r_mw.rd),
        .i_src(r_dx.rt), .i_use(r_dx.uses_rt), .o_match(w_b_wx)
    );
    hazard_entry_match u_wm (
        .i_valid(r_mw.valid), .i_rwe(r_mw.rwe), .i_rd(r_mw.rd),
        .i_src(r_xm.rt), .i_use(r_xm.valid & r_xm.is_store), .o_match(w_wm_hit)
    );

    assign freeze    = mem_busy;
    assign flush_fd  = br_taken & !mem_busy;
    assign stall     = w_stall_raw & !br_taken;
    assign bubble_dx = (stall | flush_fd) & !mem_busy;

    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        fwd_wm    = 1'b0;
        if (FWD_EN && r_dx.valid) begin
            fwd_a_sel = fwd_pick(w_a_mx, w_a_wx);
            fwd_b_sel = fwd_pick(w_b_mx, w_b_wx);
            fwd_wm    = w_wm_hit;
        end
    end

    assign w_dx_next = (stall | br_taken | !dec_valid) ? ENTRY_EMPTY : w_dec;

    // NOTE: state registers use non-blocking assignment so all stages shift on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dx        <= ENTRY_EMPTY;
            r_xm        <= ENTRY_EMPTY;
            r_mw        <= ENTRY_EMPTY;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            r_mw <= r_xm;
            r_xm <= r_dx;
            r_dx <= w_dx_next;
            if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_fd && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    // Only some fields of each stage record feed the hazard logic.
    assign w_unused = ^{r_dx, r_xm, r_mw, w_dec_rs_hit, w_dec_rt_hit};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table on the bypass
// configuration plus hand-written interlock, saturation and reset sequences.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       vld, urs, urt, rwe, ld, st;
        logic [4:0] rs, rt, rd;
    } dec_t;

    typedef struct {
        dec_t       d;
        logic       br, busy;
        logic       st, bub, fl, fz;
        logic [1:0] fa, fb;
        logic       wm;
        int         sc, fc;
    } vec_t;

    logic       clk, rst;
    logic       dec_valid, dec_uses_rs, dec_uses_rt, dec_rwe, dec_is_load, dec_is_store;
    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic       br_taken, mem_busy;

    logic        f_stall, f_bub, f_flush, f_frz, f_wm;
    logic [1:0]  f_fa, f_fb;
    logic [31:0] f_scnt, f_fcnt;
    logic        k_stall, k_bub, k_flush, k_frz, k_wm;
    logic [1:0]  k_fa, k_fb;
    logic [31:0] k_scnt, k_fcnt;
    logic        s_stall, s_bub, s_flush, s_frz, s_wm;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_scnt, s_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
        .clock(clk), .reset(rst), .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs),
        .dec_uses_rt(dec_uses_rt), .dec_rwe(dec_rwe), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .br_taken(br_taken), .mem_busy(mem_busy), .stall(f_stall), .bubble_dx(f_bub),
        .flush_fd(f_flush), .freeze(f_frz), .fwd_a_sel(f_fa), .fwd_b_sel(f_fb),
        .fwd_wm(f_wm), .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(32)) u_ilk (
        .clock(clk), .reset(rst), .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs),
        .dec_uses_rt(dec_uses_rt), .dec_rwe(dec_rwe), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .br_taken(br_taken), .mem_busy(mem_busy), .stall(k_stall), .bubble_dx(k_bub),
        .flush_fd(k_flush), .freeze(k_frz), .fwd_a_sel(k_fa), .fwd_b_sel(k_fb),
        .fwd_wm(k_wm), .stall_cnt(k_scnt), .flush_cnt(k_fcnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) u_sat (
        .clock(clk), .reset(rst), .dec_valid(dec_valid), .dec_uses_rs(dec_uses_rs),
        .dec_uses_rt(dec_uses_rt), .dec_rwe(dec_rwe), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
        .br_taken(br_taken), .mem_busy(mem_busy), .stall(s_stall), .bubble_dx(s_bub),
        .flush_fd(s_flush), .freeze(s_frz), .fwd_a_sel(s_fa), .fwd_b_sel(s_fb),
        .fwd_wm(s_wm), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic dec_t nop();
        return '0;
    endfunction

    function automatic dec_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        dec_t d = '0;
        d.vld = 1'b1; d.urs = 1'b1; d.urt = 1'b1; d.rwe = 1'b1;
        d.rs = rs; d.rt = rt; d.rd = rd;
        return d;
    endfunction

    function automatic dec_t lw(input logic [4:0] rd, input logic [4:0] rs);
        dec_t d = '0;
        d.vld = 1'b1; d.urs = 1'b1; d.rwe = 1'b1; d.ld = 1'b1;
        d.rs = rs; d.rd = rd;
        return d;
    endfunction

    function automatic dec_t sw(input logic [4:0] rt, input logic [4:0] rs);
        dec_t d = '0;
        d.vld = 1'b1; d.urs = 1'b1; d.urt = 1'b1; d.st = 1'b1;
        d.rs = rs; d.rt = rt;
        return d;
    endfunction

    function automatic vec_t mk(input dec_t d, input logic br, input logic busy,
                                input logic st, input logic bub, input logic fl, input logic fz,
                                input logic [1:0] fa, input logic [1:0] fb, input logic wm,
                                input int sc, input int fc);
        vec_t v;
        v.d = d; v.br = br; v.busy = busy;
        v.st = st; v.bub = bub; v.fl = fl; v.fz = fz;
        v.fa = fa; v.fb = fb; v.wm = wm; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input dec_t d, input logic br, input logic busy);
        dec_valid    = d.vld;
        dec_uses_rs  = d.urs;
        dec_uses_rt  = d.urt;
        dec_rwe      = d.rwe;
        dec_is_load  = d.ld;
        dec_is_store = d.st;
        dec_rs       = d.rs;
        dec_rt       = d.rt;
        dec_rd       = d.rd;
        br_taken     = br;
        mem_busy     = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(nop(), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tv [26];

    initial begin
        rst = 1'b0;
        drive(nop(), 1'b0, 1'b0);

        // d, br, busy | stall, bubble, flush, freeze, fa, fb, wm, stall_cnt, flush_cnt
        tv[0]  = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        tv[1]  = mk(lw(8, 1),      0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        tv[2]  = mk(alu(9, 8, 10), 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0);
        tv[3]  = mk(alu(9, 8, 10), 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[4]  = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 1, 0);
        tv[5]  = mk(alu(3, 1, 2),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[6]  = mk(alu(4, 3, 3),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[7]  = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 1, 0);
        tv[8]  = mk(alu(3, 1, 2),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[9]  = mk(alu(3, 4, 0),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[10] = mk(alu(4, 3, 3),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[11] = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 0, 1, 0);
        tv[12] = mk(lw(5, 1),      0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[13] = mk(sw(5, 6),      0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[14] = mk(alu(9, 1, 2),  0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 1, 0);
        tv[15] = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0);
        tv[16] = mk(lw(0, 1),      0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[17] = mk(alu(9, 0, 0),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[18] = mk(alu(0, 1, 2),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[19] = mk(alu(5, 0, 0),  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[20] = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[21] = mk(lw(8, 1),      0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[22] = mk(alu(9, 8, 10), 1, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 1, 0);
        tv[23] = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1);
        tv[24] = mk(nop(),         1, 1, 0, 0, 0, 1, 2'd0, 2'd0, 0, 1, 1);
        tv[25] = mk(nop(),         0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1);

        // Bypass configuration, one table row per cycle.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive(tv[i].d, tv[i].br, tv[i].busy);
            #2;
            check($sformatf("row%0d stall", i),     32'(f_stall), 32'(tv[i].st));
            check($sformatf("row%0d bubble_dx", i), 32'(f_bub),   32'(tv[i].bub));
            check($sformatf("row%0d flush_fd", i),  32'(f_flush), 32'(tv[i].fl));
            check($sformatf("row%0d freeze", i),    32'(f_frz),   32'(tv[i].fz));
            check($sformatf("row%0d fwd_a_sel", i), 32'(f_fa),    32'(tv[i].fa));
            check($sformatf("row%0d fwd_b_sel", i), 32'(f_fb),    32'(tv[i].fb));
            check($sformatf("row%0d fwd_wm", i),    32'(f_wm),    32'(tv[i].wm));
            check($sformatf("row%0d stall_cnt", i), f_scnt,       tv[i].sc);
            check($sformatf("row%0d flush_cnt", i), f_fcnt,       tv[i].fc);
            step();
        end

        // Full interlock: producer r3 followed by its consumer, with a 2-cycle freeze.
        do_reset();
        drive(alu(3, 1, 2), 1'b0, 1'b0);
        #2;
        check("ilk reset stall", 32'(k_stall), 32'd0);
        check("ilk reset stall_cnt", k_scnt, 32'd0);
        check("ilk reset fwd_a_sel", 32'(k_fa), 32'd0);
        step();
        drive(alu(4, 3, 0), 1'b0, 1'b0);
        #2;
        check("ilk dx stall", 32'(k_stall), 32'd1);
        check("ilk dx bubble", 32'(k_bub), 32'd1);
        check("ilk dx stall_cnt", k_scnt, 32'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(alu(4, 3, 0), 1'b0, 1'b1);
            #2;
            check($sformatf("ilk frz%0d freeze", k), 32'(k_frz), 32'd1);
            check($sformatf("ilk frz%0d bubble", k), 32'(k_bub), 32'd0);
            check($sformatf("ilk frz%0d stall_cnt", k), k_scnt, 32'd1);
            step();
        end
        drive(alu(4, 3, 0), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #2;
            check($sformatf("ilk xm/mw%0d stall", k), 32'(k_stall), 32'd1);
            check($sformatf("ilk xm/mw%0d stall_cnt", k), k_scnt, 32'(1 + k));
            step();
        end
        #2;
        check("ilk release stall", 32'(k_stall), 32'd0);
        check("ilk release bubble", 32'(k_bub), 32'd0);
        check("ilk release stall_cnt", k_scnt, 32'd3);
        check("sat stall_cnt at 3", 32'(s_scnt), 32'd3);
        step();
        drive(alu(5, 4, 0), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("ilk second%0d stall", k), 32'(k_stall), 32'd1);
            check($sformatf("ilk second%0d stall_cnt", k), k_scnt, 32'(3 + k));
            step();
        end
        #2;
        check("ilk second release stall", 32'(k_stall), 32'd0);
        check("ilk stall_cnt 6", k_scnt, 32'd6);
        check("sat stall_cnt held", 32'(s_scnt), 32'd3);
        step();

        // Five back-to-back redirects: the 2-bit flush counter must stop at all-ones.
        drive(nop(), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #2;
            check($sformatf("br%0d flush_fd", k), 32'(k_flush), 32'd1);
            check($sformatf("br%0d flush_cnt", k), k_fcnt, 32'(k));
            step();
        end
        drive(nop(), 1'b0, 1'b0);
        #2;
        check("br done flush_fd", 32'(k_flush), 32'd0);
        check("br done flush_cnt", k_fcnt, 32'd5);
        check("sat flush_cnt", 32'(s_fcnt), 32'd3);
        step();

        // Reset (with freeze asserted) in the middle of a load-use stall.
        do_reset();
        drive(lw(8, 1), 1'b0, 1'b0);
        step();
        drive(alu(9, 8, 10), 1'b0, 1'b0);
        #2;
        check("midrst stall before", 32'(f_stall), 32'd1);
        rst = 1'b1;
        mem_busy = 1'b1;
        step();
        rst = 1'b0;
        mem_busy = 1'b0;
        #2;
        check("midrst stall after", 32'(f_stall), 32'd0);
        check("midrst bubble after", 32'(f_bub), 32'd0);
        check("midrst stall_cnt", f_scnt, 32'd0);
        check("midrst flush_cnt", f_fcnt, 32'd0);
        step();
        drive(nop(), 1'b0, 1'b0);
        #2;
        check("midrst load discarded fwd_a", 32'(f_fa), 32'd0);
        check("midrst stall_cnt later", f_scnt, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
